// File: rtl/kc87_pkg.sv
// ============================================================================
//  Module      : kc87_pkg
//  Description : Shared types and constants for the KC87 TAP tape loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package kc87_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SIG   = 3'd1,
    HBN   = 3'd2,
    HDR   = 3'd3,
    BN    = 3'd4,
    DAT   = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } tap_state_t;

  localparam logic [7:0] TAP_SIG0      = 8'hC3;
  localparam logic [6:0] HDR_START_OFS = 7'd17;
  localparam logic [6:0] HDR_END_OFS   = 7'd19;
  localparam logic [6:0] HDR_EXEC_OFS  = 7'd21;

  // States in which a TAP load is in progress
  function automatic logic is_active(input tap_state_t s);
    return s inside {SIG, HBN, HDR, BN, DAT};
  endfunction

endpackage

`default_nettype wire

// File: rtl/kc87_tap_loader.sv
// ============================================================================
//  Module      : kc87_tap_loader
//  Description : Parses a KC-TAP container from the ioctl download stream and
//                writes its payload into KC87 RAM. Optional autostart pulse
//                is enabled by defining KC87_TAP_AUTOSTART_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module kc87_tap_loader
  import kc87_pkg::*;
#(
  parameter logic [7:0] TAP_INDEX = 8'd1,
  parameter int         SIG_LEN   = 16,
  parameter int         BLK_LEN   = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic        mem_ack,
  output logic        busy,
  output logic        load_ok,
  output logic        load_err,
  output logic [15:0] start_addr,
  output logic [15:0] end_addr,
  output logic [15:0] exec_addr
`ifdef KC87_TAP_AUTOSTART_EN
  ,
  output logic        autostart
`endif
);

  localparam logic [6:0] SIG_LAST = 7'(SIG_LEN - 1);
  localparam logic [6:0] BLK_LAST = 7'(BLK_LEN - 1);
  localparam logic [6:0] HDR_LAST = 7'd127;

  tap_state_t  state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [16:0] ptr_q, ptr_d;
  logic [15:0] start_q, start_d, end_q, end_d, exec_q, exec_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_din_q, mem_din_d;
  logic        mem_wr_q, mem_wr_d, wait_q, wait_d, busy_q, busy_d;
  logic        ok_q, ok_d, err_q, err_d, dl_q, dl_d, end_pend_q, end_pend_d;
`ifdef KC87_TAP_AUTOSTART_EN
  logic        as_q, as_d;
`endif

  logic w_dl_rise, w_dl_fall;
  assign w_dl_rise = ioctl_download & ~dl_q;
  assign w_dl_fall = ~ioctl_download & dl_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    start_d    = start_q;
    end_d      = end_q;
    exec_d     = exec_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_wr_d   = mem_wr_q;
    wait_d     = wait_q;
    ok_d       = 1'b0;
    err_d      = err_q;
    dl_d       = ioctl_download;
    end_pend_d = end_pend_q;
`ifdef KC87_TAP_AUTOSTART_EN
    as_d       = 1'b0;
`endif

    if (mem_wr_q && mem_ack) begin
      mem_wr_d = 1'b0;
      wait_d   = 1'b0;
    end

    if (ioctl_wr && is_active(state_q)) begin
      if (mem_wr_q) begin
        state_d = ERROR;
      end else begin
        case (state_q)
          SIG: begin
            if (cnt_q == 7'd0 && ioctl_data != TAP_SIG0) begin
              state_d = ERROR;
            end else if (cnt_q == SIG_LAST) begin
              state_d = HBN;
              cnt_d   = 7'd0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          HBN: begin
            state_d = HDR;
            cnt_d   = 7'd0;
          end
          HDR: begin
            case (cnt_q)
              HDR_START_OFS:        start_d[7:0]  = ioctl_data;
              HDR_START_OFS + 7'd1: start_d[15:8] = ioctl_data;
              HDR_END_OFS:          end_d[7:0]    = ioctl_data;
              HDR_END_OFS + 7'd1:   end_d[15:8]   = ioctl_data;
              HDR_EXEC_OFS:         exec_d[7:0]   = ioctl_data;
              HDR_EXEC_OFS + 7'd1:  exec_d[15:8]  = ioctl_data;
              default: ;
            endcase
            if (cnt_q == HDR_LAST) begin
              ptr_d   = {1'b0, start_q};
              cnt_d   = 7'd0;
              state_d = (end_q < start_q) ? ERROR : BN;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          BN: begin
            state_d = DAT;
            cnt_d   = 7'd0;
          end
          DAT: begin
            if (ptr_q <= {1'b0, end_q}) begin
              mem_wr_d   = 1'b1;
              wait_d     = 1'b1;
              mem_addr_d = ptr_q[15:0];
              mem_din_d  = ioctl_data;
            end
            // Saturate at 0x10000 so a long tail can never wrap back into range
            if (!ptr_q[16]) ptr_d = ptr_q + 17'd1;
            if (cnt_q == BLK_LAST) begin
              state_d = BN;
              cnt_d   = 7'd0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          default: ;
        endcase
      end
    end

    if (w_dl_fall && is_active(state_d)) end_pend_d = 1'b1;

    // End-of-download verdict waits until no write is outstanding
    if (end_pend_d && !mem_wr_d && is_active(state_d)) begin
      end_pend_d = 1'b0;
      if ((state_d == BN || state_d == DAT) && ptr_d > {1'b0, end_q}) begin
        state_d = DONE;
        ok_d    = 1'b1;
`ifdef KC87_TAP_AUTOSTART_EN
        as_d    = (exec_q != 16'hFFFF);
`endif
      end else begin
        state_d = ERROR;
      end
    end

    if (state_q == DONE) state_d = IDLE;
    if (state_q == ERROR && w_dl_fall) state_d = IDLE;

    if (w_dl_rise && ioctl_index == TAP_INDEX) begin
      state_d    = SIG;
      cnt_d      = 7'd0;
      ptr_d      = 17'd0;
      start_d    = 16'd0;
      end_d      = 16'd0;
      exec_d     = 16'd0;
      err_d      = 1'b0;
      mem_wr_d   = 1'b0;
      wait_d     = 1'b0;
      end_pend_d = 1'b0;
    end

    if (state_d == ERROR) begin
      err_d      = 1'b1;
      mem_wr_d   = 1'b0;
      wait_d     = 1'b0;
      end_pend_d = 1'b0;
    end

    busy_d = is_active(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 7'd0;
      ptr_q      <= 17'd0;
      start_q    <= 16'd0;
      end_q      <= 16'd0;
      exec_q     <= 16'd0;
      mem_addr_q <= 16'd0;
      mem_din_q  <= 8'd0;
      mem_wr_q   <= 1'b0;
      wait_q     <= 1'b0;
      busy_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      dl_q       <= 1'b0;
      end_pend_q <= 1'b0;
`ifdef KC87_TAP_AUTOSTART_EN
      as_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      start_q    <= start_d;
      end_q      <= end_d;
      exec_q     <= exec_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_wr_q   <= mem_wr_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      dl_q       <= dl_d;
      end_pend_q <= end_pend_d;
`ifdef KC87_TAP_AUTOSTART_EN
      as_q       <= as_d;
`endif
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign busy       = busy_q;
  assign load_ok    = ok_q;
  assign load_err   = err_q;
  assign start_addr = start_q;
  assign end_addr   = end_q;
  assign exec_addr  = exec_q;
`ifdef KC87_TAP_AUTOSTART_EN
  assign autostart  = as_q;
`endif

endmodule

`default_nettype wire
